// File: rtl/vbuf_ram_pkg.sv
// Shared constants for the video-buffer RAM and the requesters that share it.
package vbuf_ram_pkg;
    localparam int VBUF_RAM_DW     = 2048;
    localparam int VBUF_RAM_AW     = 12;
    localparam int VBUF_RAM_DEPTH  = 4096;
    localparam int VBUF_RAM_MAX_WR = 8;
    localparam int VBUF_RAM_MAX_RD = 8;
endpackage

// File: rtl/vbuf_ram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or above the pointer,
// wrapping at N-1; the pointer moves one past the winner.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_gnt_o
);
    logic [IW-1:0] ptr_q, ptr_d;
    int            cand;

    always_comb begin
        gnt_o     = '0;
        idx_o     = '0;
        any_gnt_o = 1'b0;
        cand      = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) cand = cand - N;
            if (!any_gnt_o && req_i[cand]) begin
                any_gnt_o   = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end
        end
        // Grants are held off during reset so nothing reaches the RAM ports.
        if (!rst_n) begin
            gnt_o     = '0;
            idx_o     = '0;
            any_gnt_o = 1'b0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt_o) ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/vbuf_ram_port_arbiter.sv
// Shares one two-port RAM between write and read requesters with one round-robin
// arbiter per port. Optional write-first bypass: VBUF_RAM_ARB_BYPASS_EN.
module vbuf_ram_port_arbiter
    import vbuf_ram_pkg::*;
#(
    parameter int NUM_WR = 4,
    parameter int NUM_RD = 4,
    parameter int DW     = VBUF_RAM_DW,
    parameter int AW     = VBUF_RAM_AW,
    parameter int IDW    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WR-1:0]    wr_req,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR*DW-1:0] wr_data,
    output logic [NUM_WR-1:0]    wr_gnt,
    input  logic [NUM_RD-1:0]    rd_req,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_gnt,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_data,
    output logic                 ram_w_en,
    output logic [AW-1:0]        ram_w_addr,
    output logic [DW-1:0]        ram_w_data,
    output logic                 ram_r_en,
    output logic [AW-1:0]        ram_r_addr,
    input  logic [DW-1:0]        ram_r_data
);
    logic [IDW-1:0] wr_idx, rd_idx;
    logic           wr_any, rd_any;
    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;

    rr_arbiter #(.N(NUM_WR), .IW(IDW)) u_wr_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (wr_req),
        .gnt_o    (wr_gnt),
        .idx_o    (wr_idx),
        .any_gnt_o(wr_any)
    );

    rr_arbiter #(.N(NUM_RD), .IW(IDW)) u_rd_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (rd_req),
        .gnt_o    (rd_gnt),
        .idx_o    (rd_idx),
        .any_gnt_o(rd_any)
    );

    always_comb begin
        ram_w_en   = wr_any;
        ram_w_addr = '0;
        ram_w_data = '0;
        ram_r_en   = rd_any;
        ram_r_addr = '0;
        if (wr_any) begin
            ram_w_addr = wr_addr[int'(wr_idx)*AW +: AW];
            ram_w_data = wr_data[int'(wr_idx)*DW +: DW];
        end
        if (rd_any) ram_r_addr = rd_addr[int'(rd_idx)*AW +: AW];
    end

    // The RAM registers read data, so the tag is delayed by one cycle to line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= rd_any;
            rsp_id_q    <= rd_idx;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;

`ifdef VBUF_RAM_ARB_BYPASS_EN
    logic          hit_d, hit_q;
    logic [DW-1:0] byp_data_q;

    assign hit_d = ram_w_en && ram_r_en && (ram_w_addr == ram_r_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            hit_q <= hit_d;
            if (hit_d) byp_data_q <= ram_w_data;
        end
    end

    assign rsp_data = hit_q ? byp_data_q : ram_r_data;
`else
    assign rsp_data = ram_r_data;
`endif
endmodule

// File: tb/tb_vbuf_ram_port_arbiter.sv
// Self-checking bench for vbuf_ram_port_arbiter with a behavioural RAM and a
// queue-free reference model of both round-robin ports.
module tb_vbuf_ram_port_arbiter;
    localparam int NW = 4;
    localparam int NR = 4;
    localparam int DW = 2048;
    localparam int AW = 12;
`ifdef VBUF_RAM_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NW-1:0]    wr_req = '0;
    logic [NW*AW-1:0] wr_addr = '0;
    logic [NW*DW-1:0] wr_data = '0;
    logic [NW-1:0]    wr_gnt;
    logic [NR-1:0]    rd_req = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR-1:0]    rd_gnt;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic [DW-1:0]    rsp_data;
    logic             ram_w_en;
    logic [AW-1:0]    ram_w_addr;
    logic [DW-1:0]    ram_w_data;
    logic             ram_r_en;
    logic [AW-1:0]    ram_r_addr;
    logic [DW-1:0]    ram_r_data = '0;

    int checks = 0;
    int errors = 0;

    vbuf_ram_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .ram_w_en  (ram_w_en),
        .ram_w_addr(ram_w_addr),
        .ram_w_data(ram_w_data),
        .ram_r_en  (ram_r_en),
        .ram_r_addr(ram_r_addr),
        .ram_r_data(ram_r_data)
    );

    always #5 clk = ~clk;

    // Behavioural two-port RAM: registered read, read-before-write.
    logic [DW-1:0] mem [int];
    always @(posedge clk) begin
        if (ram_r_en) ram_r_data <= mem.exists(int'(ram_r_addr)) ? mem[int'(ram_r_addr)] : '0;
        if (ram_w_en) mem[int'(ram_w_addr)] = ram_w_data;
    end

    function automatic logic [63:0] fold(input logic [DW-1:0] d);
        logic [63:0] f = '0;
        for (int j = 0; j < DW / 64; j++) f ^= d[j*64 +: 64];
        return f;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int j = 0; j < DW / 32; j++) w[j*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        logic [DW-1:0] w;
        for (int j = 0; j < DW / 8; j++) w[j*8 +: 8] = b;
        return w;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        wr_req = '0;
        rd_req = '0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        wr_req = '1;
        rd_req = '1;
        @(negedge clk);
        checks++;
        if ({wr_gnt, rd_gnt, ram_w_en, ram_r_en} !== '0) begin
            errors++;
            $display("FAIL reset_grants: got wg=%b rg=%b we=%b re=%b, want all 0",
                     wr_gnt, rd_gnt, ram_w_en, ram_r_en);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b id=%0d, want 0/0", rsp_valid, rsp_id);
        end
        apply_reset();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] a5 = fill(8'hA5);
        apply_reset();
        wr_req = 4'b0100;
        wr_addr[2*AW +: AW] = 12'h123;
        wr_data[2*DW +: DW] = a5;
        @(negedge clk);
        checks++;
        if (wr_gnt !== 4'b0100 || ram_w_en !== 1'b1 || ram_w_addr !== 12'h123 || ram_w_data !== a5) begin
            errors++;
            $display("FAIL single_write: got gnt=%b en=%b addr=%h dfold=%h, want 0100/1/123/%h",
                     wr_gnt, ram_w_en, ram_w_addr, fold(ram_w_data), fold(a5));
        end
        next_cycle();
        wr_req = '0;
        rd_req = 4'b0010;
        rd_addr[1*AW +: AW] = 12'h123;
        @(negedge clk);
        checks++;
        if (rd_gnt !== 4'b0010 || ram_r_en !== 1'b1 || ram_r_addr !== 12'h123) begin
            errors++;
            $display("FAIL single_read_gnt: got gnt=%b en=%b addr=%h, want 0010/1/123",
                     rd_gnt, ram_r_en, ram_r_addr);
        end
        next_cycle();
        rd_req = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== a5) begin
            errors++;
            $display("FAIL single_read_rsp: got valid=%b id=%0d dfold=%h, want 1/1/%h",
                     rsp_valid, rsp_id, fold(rsp_data), fold(a5));
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse: got valid=%b, want 0", rsp_valid);
        end
        next_cycle();
    endtask

    task automatic test_read_contention();
        apply_reset();
        rd_req = '1;
        for (int c = 0; c <= 8; c++) begin
            if (c == 8) rd_req = '0;
            @(negedge clk);
            checks++;
            if (rd_gnt !== ((c < 8) ? 4'(1 << (c % 4)) : 4'b0000)) begin
                errors++;
                $display("FAIL contention_gnt c=%0d: got %b, want %b", c, rd_gnt,
                         (c < 8) ? 4'(1 << (c % 4)) : 4'b0000);
            end
            checks++;
            if (rsp_valid !== (c >= 1) || (c >= 1 && rsp_id !== 2'((c - 1) % 4))) begin
                errors++;
                $display("FAIL contention_rsp c=%0d: got valid=%b id=%0d, want %b/%0d",
                         c, rsp_valid, rsp_id, c >= 1, (c - 1) % 4);
            end
            next_cycle();
        end
    endtask

    task automatic test_pointer_skip();
        logic [3:0] reqs [7] = '{4'b0010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
        logic [3:0] gnts [7] = '{4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            rd_req = reqs[c];
            wr_req = reqs[c];
            @(negedge clk);
            checks++;
            if (rd_gnt !== gnts[c] || wr_gnt !== gnts[c]) begin
                errors++;
                $display("FAIL pointer_skip c=%0d: got rg=%b wg=%b, want %b", c, rd_gnt, wr_gnt, gnts[c]);
            end
            next_cycle();
        end
        rd_req = '0;
        wr_req = '0;
        next_cycle();
    endtask

    task automatic test_collision();
        logic [DW-1:0] d11 = fill(8'h11);
        logic [DW-1:0] d22 = fill(8'h22);
        apply_reset();
        wr_req = 4'b0001;
        wr_addr[0 +: AW] = 12'h7FF;
        wr_data[0 +: DW] = d11;
        next_cycle();
        wr_req = 4'b1000;
        wr_addr[3*AW +: AW] = 12'h7FF;
        wr_data[3*DW +: DW] = d22;
        rd_req = 4'b0001;
        rd_addr[0 +: AW] = 12'h7FF;
        next_cycle();
        wr_req = '0;
        rd_req = 4'b0010;
        rd_addr[1*AW +: AW] = 12'h7FF;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== (BYP ? d22 : d11)) begin
            errors++;
            $display("FAIL collision: got valid=%b dfold=%h, want 1/%h",
                     rsp_valid, fold(rsp_data), fold(BYP ? d22 : d11));
        end
        next_cycle();
        rd_req = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== d22) begin
            errors++;
            $display("FAIL after_collision: got valid=%b id=%0d dfold=%h, want 1/1/%h",
                     rsp_valid, rsp_id, fold(rsp_data), fold(d22));
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] d33 = fill(8'h33);
        apply_reset();
        wr_req = 4'b0001;
        wr_addr[0 +: AW] = 12'h055;
        wr_data[0 +: DW] = d33;
        next_cycle();
        wr_req = '0;
        rd_req = 4'b0001;
        rd_addr[0 +: AW] = 12'h055;
        next_cycle();
        rd_req = '0;
        rst_n  = 1'b0;
        wr_req = 4'b0001;
        wr_data[0 +: DW] = fill(8'h77);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_rsp: got valid=%b, want 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (wr_gnt !== 4'b0000 || ram_w_en !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got wg=%b we=%b valid=%b, want 0/0/0", wr_gnt, ram_w_en, rsp_valid);
        end
        next_cycle();
        rst_n  = 1'b1;
        wr_req = '1;
        rd_req = '1;
        for (int i = 1; i < NW; i++) wr_addr[i*AW +: AW] = 12'h600;
        for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = 12'h055;
        @(negedge clk);
        checks++;
        if (rd_gnt !== 4'b0001 || wr_gnt !== 4'b0001 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ptr: got rg=%b wg=%b valid=%b, want 0001/0001/0", rd_gnt, wr_gnt, rsp_valid);
        end
        next_cycle();
        wr_req = '0;
        rd_req = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== d33) begin
            errors++;
            $display("FAIL reset_dropped_write: got valid=%b id=%0d dfold=%h, want 1/0/%h",
                     rsp_valid, rsp_id, fold(rsp_data), fold(d33));
        end
        next_cycle();
    endtask

    task automatic test_boundaries();
        logic [DW-1:0] x = rand_word();
        logic [DW-1:0] y = rand_word();
        x[0] = 1'b0;
        y[0] = 1'b1;
        apply_reset();
        wr_req = 4'b0010;
        wr_addr[1*AW +: AW] = 12'h000;
        wr_data[1*DW +: DW] = x;
        next_cycle();
        wr_req = 4'b0100;
        wr_addr[2*AW +: AW] = 12'hFFF;
        wr_data[2*DW +: DW] = y;
        next_cycle();
        wr_req = '0;
        rd_req = 4'b1001;
        rd_addr[3*AW +: AW] = 12'h000;
        rd_addr[0 +: AW]    = 12'hFFF;
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== y) begin
            errors++;
            $display("FAIL boundary_fff: got valid=%b id=%0d dfold=%h, want 1/0/%h",
                     rsp_valid, rsp_id, fold(rsp_data), fold(y));
        end
        next_cycle();
        rd_req = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== x) begin
            errors++;
            $display("FAIL boundary_000: got valid=%b id=%0d dfold=%h, want 1/3/%h",
                     rsp_valid, rsp_id, fold(rsp_data), fold(x));
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [int];
        int wp = 0, rp = 0, ew, er, k, pid = 0;
        bit pv = 1'b0;
        logic [DW-1:0] pdata = '0;
        logic [DW-1:0] wd;
        int wa, ra;
        apply_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            wr_req = 4'($urandom);
            rd_req = 4'($urandom);
            for (int i = 0; i < NW; i++) begin
                wr_addr[i*AW +: AW] = 12'(12'h400 + $urandom_range(0, 7));
                wr_data[i*DW +: DW] = rand_word();
            end
            for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = 12'(12'h400 + $urandom_range(0, 7));
            ew = -1;
            er = -1;
            for (int i = 0; i < NW; i++) begin
                k = (wp + i) % NW;
                if (ew < 0 && wr_req[k]) ew = k;
            end
            for (int i = 0; i < NR; i++) begin
                k = (rp + i) % NR;
                if (er < 0 && rd_req[k]) er = k;
            end
            wa = (ew >= 0) ? int'(wr_addr[ew*AW +: AW]) : 0;
            wd = (ew >= 0) ? wr_data[ew*DW +: DW] : '0;
            ra = (er >= 0) ? int'(rd_addr[er*AW +: AW]) : 0;
            @(negedge clk);
            checks++;
            if (wr_gnt !== ((ew >= 0) ? 4'(1 << ew) : 4'b0) || rd_gnt !== ((er >= 0) ? 4'(1 << er) : 4'b0)) begin
                errors++;
                $display("FAIL rand_gnt cyc=%0d: got wg=%b rg=%b, want winners w=%0d r=%0d",
                         cyc, wr_gnt, rd_gnt, ew, er);
            end
            checks++;
            if (ram_w_en !== (ew >= 0) || int'(ram_w_addr) !== wa || ram_w_data !== wd) begin
                errors++;
                $display("FAIL rand_wpath cyc=%0d: got en=%b addr=%h dfold=%h, want %b/%h/%h",
                         cyc, ram_w_en, ram_w_addr, fold(ram_w_data), ew >= 0, wa, fold(wd));
            end
            checks++;
            if (ram_r_en !== (er >= 0) || (er >= 0 && int'(ram_r_addr) !== ra)) begin
                errors++;
                $display("FAIL rand_rpath cyc=%0d: got en=%b addr=%h, want %b/%h",
                         cyc, ram_r_en, ram_r_addr, er >= 0, ra);
            end
            checks++;
            if (rsp_valid !== pv || (pv && (int'(rsp_id) !== pid || rsp_data !== pdata))) begin
                errors++;
                $display("FAIL rand_rsp cyc=%0d: got valid=%b id=%0d dfold=%h, want %b/%0d/%h",
                         cyc, rsp_valid, rsp_id, fold(rsp_data), pv, pid, fold(pdata));
            end
            pv = (er >= 0);
            if (er >= 0) begin
                pid = er;
                if (BYP && ew >= 0 && wa == ra) pdata = wd;
                else pdata = ref_mem.exists(ra) ? ref_mem[ra] : '0;
            end
            if (ew >= 0) begin
                ref_mem[wa] = wd;
                wp = (ew + 1) % NW;
            end
            if (er >= 0) rp = (er + 1) % NR;
            next_cycle();
        end
        wr_req = '0;
        rd_req = '0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_contention();
        test_pointer_skip();
        test_collision();
        test_reset_mid_read();
        test_boundaries();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
